mult_err_stats: RTL

Streaming error-metric accumulator that sits directly downstream of the exact and approximate 8×8 multipliers. Each accepted pair of products updates running error statistics:

- sample count
- signed error sum
- absolute error sum
- nonzero-error count
- maximum absolute error

Software or a top-level sweep controller derives MED/NMED from these totals after `o_done`. It replaces offline summation with a synthesizable, cycle-accurate stage.

---
 rtl/mult_err_stats.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mult_err_stats.sv
// mult_err_stats: running error statistics (count, signed/abs sums, nonzero count, max) of approx vs exact products.
// Latency: a sample accepted at edge k shows in the statistics after edge k+1; o_done follows the i_last accept by one edge.
// Backpressure: o_ready is registered from FSM state, high only in RUN; max tracking is built only with MULT_ERR_MAX_TRACK_EN.
module mult_err_stats #(
   parameter int W_IN  = 16,
   parameter int W_ACC = 40,
   parameter int W_CNT = 24
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic signed [W_IN-1:0]  i_exact,
   input  logic signed [W_IN-1:0]  i_approx,
   input  logic                    i_last,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [W_CNT-1:0]        o_count,
   output logic [W_CNT-1:0]        o_err_cnt,
   output logic [W_ACC-1:0]        o_sum_err,
   output logic [W_ACC-1:0]        o_sum_abs,
   output logic [W_IN:0]           o_max_err,
   output logic                    o_ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [W_CNT-1:0] CNT_MAX = '1;
   localparam logic [W_ACC-1:0] ACC_POS = {1'b0, {(W_ACC-1){1'b1}}};
   localparam logic [W_ACC-1:0] ACC_NEG = {1'b1, {(W_ACC-1){1'b0}}};

   state_t state;

   // A start pulse wins over a sample presented in the same cycle.
   logic accept;
   assign accept = i_valid & o_ready & ~i_start;

   // Stage-1 difference and magnitude of the incoming pair.
   logic signed [W_IN:0] d_comb;
   logic        [W_IN:0] a_comb;
   assign d_comb = $signed({i_approx[W_IN-1], i_approx}) - $signed({i_exact[W_IN-1], i_exact});
   assign a_comb = d_comb[W_IN] ? $unsigned(-d_comb) : $unsigned(d_comb);

   logic                 s1_vld;
   logic signed [W_IN:0] s1_d;
   logic        [W_IN:0] s1_a;
   logic                 s1_nz;

   // FSM with registered handshake/status outputs; start restarts from any state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         o_ready <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else if (i_start) begin
         state   <= RUN;
         o_ready <= 1'b1;
         o_busy  <= 1'b1;
         o_done  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (accept && i_last) begin
                  state   <= DRAIN;
                  o_ready <= 1'b0;
               end
            end
            DRAIN: begin
               state  <= DONE;
               o_busy <= 1'b0;
               o_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Stage-1 register: captures d, |d| and nonzero flag of each accepted sample.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_vld <= 1'b0;
         s1_d   <= '0;
         s1_a   <= '0;
         s1_nz  <= 1'b0;
      end else if (i_start) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_d  <= d_comb;
            s1_a  <= a_comb;
            s1_nz <= (d_comb != '0);
         end
      end
   end

   logic                  cnt_sat, errc_sat, abs_ovf, err_ovf;
   logic [W_CNT-1:0]      count_nxt, err_cnt_nxt;
   logic [W_ACC:0]        abs_wide;
   logic signed [W_ACC:0] err_wide;
   logic [W_ACC-1:0]      sum_abs_nxt, sum_err_nxt;

   // Saturating next values of the counters and accumulators.
   always_comb begin
      cnt_sat     = (o_count == CNT_MAX);
      count_nxt   = cnt_sat ? o_count : o_count + W_CNT'(1);
      errc_sat    = s1_nz && (o_err_cnt == CNT_MAX);
      err_cnt_nxt = errc_sat ? o_err_cnt : o_err_cnt + W_CNT'(s1_nz);
      abs_wide    = {1'b0, o_sum_abs} + (W_ACC+1)'(s1_a);
      abs_ovf     = abs_wide[W_ACC];
      sum_abs_nxt = abs_ovf ? '1 : abs_wide[W_ACC-1:0];
      err_wide    = $signed({o_sum_err[W_ACC-1], o_sum_err}) + (W_ACC+1)'(s1_d);
      err_ovf     = (err_wide[W_ACC] != err_wide[W_ACC-1]);
      sum_err_nxt = err_wide[W_ACC-1:0];
      if (err_ovf) begin
         sum_err_nxt = err_wide[W_ACC] ? ACC_NEG : ACC_POS;
      end
   end

   // Stage-2 statistics update; ovf is sticky until start or reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count   <= '0;
         o_err_cnt <= '0;
         o_sum_err <= '0;
         o_sum_abs <= '0;
         o_ovf     <= 1'b0;
      end else if (i_start) begin
         o_count   <= '0;
         o_err_cnt <= '0;
         o_sum_err <= '0;
         o_sum_abs <= '0;
         o_ovf     <= 1'b0;
      end else if (s1_vld) begin
         o_count   <= count_nxt;
         o_err_cnt <= err_cnt_nxt;
         o_sum_err <= sum_err_nxt;
         o_sum_abs <= sum_abs_nxt;
         o_ovf     <= o_ovf | cnt_sat | errc_sat | abs_ovf | err_ovf;
      end
   end

`ifdef MULT_ERR_MAX_TRACK_EN
   logic [W_IN:0] max_q;

   // Running maximum of |d|.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         max_q <= '0;
      end else if (i_start) begin
         max_q <= '0;
      end else if (s1_vld && (s1_a > max_q)) begin
         max_q <= s1_a;
      end
   end

   assign o_max_err = max_q;
`else
   assign o_max_err = '0;
`endif

endmodule
